abs_diff_delta_decoder: RTL and testbench

- Streaming reconstructor; the decoder end of the abs-diff delta path.
- Upstream encoder emits, per sample, a 9-bit magnitude |cur − prev| from the abs-diff datapath plus a sign bit.
- This block rebuilds the 8-bit sample stream by adding or subtracting each delta to/from a held predictor, with saturation.
- Sits between the delta channel and the sample sink; valid/ready on both sides; one output register stage.

---
 rtl/abs_diff_delta_decoder_pkg.sv | 36 +++
 rtl/abs_diff_delta_decoder_if.sv | 24 ++
 rtl/abs_diff_delta_decoder_core.sv | 44 ++++
 rtl/abs_diff_delta_decoder.sv | 105 ++++++++++
 tb/tb_abs_diff_delta_decoder.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/abs_diff_delta_decoder_pkg.sv
// Shared types and helpers for the abs-diff delta decoder.
// The optional stats counters are enabled with ABS_DIFF_DELTA_DECODER_STATS_EN.
package abs_diff_pkg;

  localparam int CNT_W = 16;
  localparam int CLAMP_W = 16;

  typedef enum logic [0:0] {
    WAIT_KEY = 1'b0,
    RUN      = 1'b1
  } state_e;

  typedef struct packed {
    logic [CLAMP_W-1:0] value;
    logic               sat;
  } sat_res_t;

  // Clamp a signed value into [0, 2^dw-1]; sat flags that clamping happened.
  function automatic sat_res_t sat_clamp(input logic signed [31:0] value, input int dw);
    sat_res_t           res;
    logic signed [31:0] max_v;
    max_v = (32'sd1 <<< dw) - 32'sd1;
    if (value < 32'sd0) begin
      res.value = {CLAMP_W{1'b0}};
      res.sat   = 1'b1;
    end else if (value > max_v) begin
      res.value = max_v[CLAMP_W-1:0];
      res.sat   = 1'b1;
    end else begin
      res.value = value[CLAMP_W-1:0];
      res.sat   = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/abs_diff_delta_decoder_if.sv
// Delta-word input and sample output handshake bundle for the decoder.
interface abs_diff_delta_decoder_if #(parameter int DW = 8);

  logic          in_valid;
  logic          in_ready;
  logic          in_key;
  logic          in_sign;
  logic [DW:0]   in_mag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_sample;
  logic          out_sat;

  modport master (
    output in_valid, in_key, in_sign, in_mag, out_ready,
    input  in_ready, out_valid, out_sample, out_sat
  );

  modport slave (
    input  in_valid, in_key, in_sign, in_mag, out_ready,
    output in_ready, out_valid, out_sample, out_sat
  );

endinterface

// File: rtl/abs_diff_delta_decoder_core.sv
// Combinational reconstruction: pred +/- mag (or keyframe value) with optional clamp.
module abs_diff_delta_core
  import abs_diff_pkg::*;
#(
  parameter int DW     = 8,
  parameter bit SAT_EN = 1'b1
) (
  input  logic [DW-1:0] pred,
  input  logic [DW:0]   mag,
  input  logic          key,
  input  logic          sign,
  output logic [DW-1:0] result,
  output logic          sat
);

  logic signed [DW+2:0] pred_s;
  logic signed [DW+2:0] mag_s;
  logic signed [DW+2:0] sum_s;
  logic signed [31:0]   wide_s;
  sat_res_t             clamp_s;

  // Three guard bits keep pred+/-mag exact before clamping or wrapping.
  always_comb begin
    pred_s = signed'({3'b000, pred});
    mag_s  = signed'({2'b00, mag});
    if (key) begin
      sum_s = mag_s;
    end else if (sign) begin
      sum_s = pred_s - mag_s;
    end else begin
      sum_s = pred_s + mag_s;
    end
    wide_s  = {{(32-(DW+3)){sum_s[DW+2]}}, sum_s};
    clamp_s = sat_clamp(wide_s, DW);
    if (SAT_EN) begin
      result = clamp_s.value[DW-1:0];
      sat    = clamp_s.sat;
    end else begin
      result = sum_s[DW-1:0];
      sat    = 1'b0;
    end
  end

endmodule

// File: rtl/abs_diff_delta_decoder.sv
// Streaming delta decoder: rebuilds samples from keyframes and signed deltas.
// Stats counters are built only when ABS_DIFF_DELTA_DECODER_STATS_EN is defined.
module abs_diff_delta_decoder
  import abs_diff_pkg::*;
#(
  parameter int DW     = 8,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  abs_diff_delta_decoder_if.slave bus,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic [CNT_W-1:0]     stat_samples,
  output logic [CNT_W-1:0]     stat_sats
);

  state_e          state_r;
  logic [DW-1:0]   pred_r;
  logic            out_valid_r;
  logic [DW-1:0]   out_sample_r;
  logic            out_sat_r;
  logic [CNT_W-1:0] drop_cnt_r;

  logic            accept_s;
  logic            xfer_s;
  logic            in_ready_s;
  logic [DW-1:0]   core_result_s;
  logic            core_sat_s;

  assign in_ready_s = !out_valid_r || bus.out_ready;
  assign accept_s   = bus.in_valid && in_ready_s;
  assign xfer_s     = out_valid_r && bus.out_ready;

  abs_diff_delta_core #(
    .DW     (DW),
    .SAT_EN (SAT_EN)
  ) u_core (
    .pred   (pred_r),
    .mag    (bus.in_mag),
    .key    (bus.in_key),
    .sign   (bus.in_sign),
    .result (core_result_s),
    .sat    (core_sat_s)
  );

  // FSM, predictor, output register and drop counter; pred advances on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= WAIT_KEY;
      pred_r       <= {DW{1'b0}};
      out_valid_r  <= 1'b0;
      out_sample_r <= {DW{1'b0}};
      out_sat_r    <= 1'b0;
      drop_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      if (accept_s && (bus.in_key || (state_r == RUN))) begin
        pred_r       <= core_result_s;
        out_sample_r <= core_result_s;
        out_sat_r    <= core_sat_s;
        out_valid_r  <= 1'b1;
        state_r      <= RUN;
      end else begin
        if (accept_s && (drop_cnt_r != {CNT_W{1'b1}})) begin
          drop_cnt_r <= drop_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (xfer_s) begin
          out_valid_r <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_sample = out_sample_r;
  assign bus.out_sat    = out_sat_r;
  assign drop_cnt       = drop_cnt_r;

`ifdef ABS_DIFF_DELTA_DECODER_STATS_EN
  logic [CNT_W-1:0] stat_samples_r;
  logic [CNT_W-1:0] stat_sats_r;

  // Saturating counts of transferred samples and of clamped ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_samples_r <= {CNT_W{1'b0}};
      stat_sats_r    <= {CNT_W{1'b0}};
    end else begin
      if (xfer_s && (stat_samples_r != {CNT_W{1'b1}})) begin
        stat_samples_r <= stat_samples_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (xfer_s && out_sat_r && (stat_sats_r != {CNT_W{1'b1}})) begin
        stat_sats_r <= stat_sats_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign stat_samples = stat_samples_r;
  assign stat_sats    = stat_sats_r;
`else
  assign stat_samples = {CNT_W{1'b0}};
  assign stat_sats    = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_abs_diff_delta_decoder.sv
// Directed, table-driven bench for abs_diff_delta_decoder; runs a clamping and a wrapping instance side by side.
module tb_abs_diff_delta_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_key = 1'b0;
  logic       in_sign = 1'b0;
  logic [8:0] in_mag = 9'd0;
  logic       out_ready = 1'b1;

  logic [15:0] drop1, stat_s1, stat_t1;
  logic [15:0] drop0, stat_s0, stat_t0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  abs_diff_delta_decoder_if #(.DW(8)) if1 ();
  abs_diff_delta_decoder_if #(.DW(8)) if0 ();

  assign if1.in_valid  = in_valid;
  assign if1.in_key    = in_key;
  assign if1.in_sign   = in_sign;
  assign if1.in_mag    = in_mag;
  assign if1.out_ready = out_ready;
  assign if0.in_valid  = in_valid;
  assign if0.in_key    = in_key;
  assign if0.in_sign   = in_sign;
  assign if0.in_mag    = in_mag;
  assign if0.out_ready = out_ready;

  abs_diff_delta_decoder #(.DW(8), .SAT_EN(1'b1)) dut_sat (
    .clk (clk), .rst (rst), .bus (if1.slave),
    .drop_cnt (drop1), .stat_samples (stat_s1), .stat_sats (stat_t1)
  );

  abs_diff_delta_decoder #(.DW(8), .SAT_EN(1'b0)) dut_wrap (
    .clk (clk), .rst (rst), .bus (if0.slave),
    .drop_cnt (drop0), .stat_samples (stat_s0), .stat_sats (stat_t0)
  );

  typedef struct packed {
    logic       rst_before;
    logic       key;
    logic       sign;
    logic [8:0] mag;
    logic       v;      // output expected after this word
    logic [7:0] e1;     // clamping instance sample
    logic       s1;     // clamping instance sat flag
    logic [7:0] e0;     // wrapping instance sample
    logic [7:0] edrop;  // expected drop count afterwards
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_row(input int i);
    if (vecs[i].rst_before) pulse_reset();
    in_valid  = 1'b1;
    in_key    = vecs[i].key;
    in_sign   = vecs[i].sign;
    in_mag    = vecs[i].mag;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk($sformatf("row%0d valid_sat", i), int'(if1.out_valid), int'(vecs[i].v));
    chk($sformatf("row%0d valid_wrap", i), int'(if0.out_valid), int'(vecs[i].v));
    if (vecs[i].v) begin
      chk($sformatf("row%0d sample_sat", i), int'(if1.out_sample), int'(vecs[i].e1));
      chk($sformatf("row%0d flag_sat", i), int'(if1.out_sat), int'(vecs[i].s1));
      chk($sformatf("row%0d sample_wrap", i), int'(if0.out_sample), int'(vecs[i].e0));
      chk($sformatf("row%0d flag_wrap", i), int'(if0.out_sat), 0);
    end
    chk($sformatf("row%0d drop", i), int'(drop1), int'(vecs[i].edrop));
  endtask

  initial begin
    //            rst   key   sign  mag      v     e1      s1    e0      drop
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 9'd5,   1'b0, 8'd0,   1'b0, 8'd0,   8'd1};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 9'd3,   1'b0, 8'd0,   1'b0, 8'd0,   8'd2};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 9'd100, 1'b1, 8'd100, 1'b0, 8'd100, 8'd2};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 9'd100, 1'b1, 8'd100, 1'b0, 8'd100, 8'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 9'd20,  1'b1, 8'd120, 1'b0, 8'd120, 8'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 9'd130, 1'b1, 8'd0,   1'b1, 8'd246, 8'd0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 9'd300, 1'b1, 8'd255, 1'b1, 8'd34,  8'd0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 9'd10,  1'b1, 8'd10,  1'b0, 8'd10,  8'd0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 9'd0,   1'b1, 8'd10,  1'b0, 8'd10,  8'd0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 9'd300, 1'b1, 8'd255, 1'b1, 8'd44,  8'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 9'd1,   1'b1, 8'd255, 1'b1, 8'd45,  8'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 9'd511, 1'b1, 8'd0,   1'b1, 8'd46,  8'd0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 9'd50,  1'b1, 8'd50,  1'b0, 8'd50,  8'd0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 9'd10,  1'b1, 8'd60,  1'b0, 8'd60,  8'd0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 9'd5,   1'b0, 8'd0,   1'b0, 8'd0,   8'd1};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 9'd7,   1'b1, 8'd7,   1'b0, 8'd7,   8'd1};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset out_valid", int'(if1.out_valid), 0);
    chk("reset out_sample", int'(if1.out_sample), 0);
    chk("reset out_sat", int'(if1.out_sat), 0);
    chk("reset drop_cnt", int'(drop1), 0);
    chk("reset in_ready", int'(if1.in_ready), 1);
    chk("reset stat_samples", int'(stat_s1), 0);

    for (int i = 0; i < 7; i++) run_row(i);
    @(negedge clk);
`ifdef ABS_DIFF_DELTA_DECODER_STATS_EN
    chk("stat_samples", int'(stat_s1), 4);
    chk("stat_sats", int'(stat_t1), 2);
`else
    chk("stat_samples off", int'(stat_s1), 0);
    chk("stat_sats off", int'(stat_t1), 0);
`endif
    for (int i = 7; i < 16; i++) run_row(i);

    // Back-pressure: key 200 then +1 deltas with out_ready cycling 1,0,0,1.
    begin
      logic       pat[4];
      int         sent;
      int         got;
      int         exp_v;
      logic       held_v;
      logic [7:0] held_s;
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      pulse_reset();
      sent = 0; got = 0; exp_v = 200; held_v = 1'b0; held_s = 8'd0;
      for (int cyc = 0; cyc < 40; cyc++) begin
        out_ready = pat[cyc % 4];
        in_valid  = (sent < 8);
        in_key    = (sent == 0);
        in_sign   = 1'b0;
        in_mag    = (sent == 0) ? 9'd200 : 9'd1;
        #1;
        if (held_v) begin
          chk("stall valid held", int'(if1.out_valid), 1);
          chk("stall sample held", int'(if1.out_sample), int'(held_s));
        end
        if (if1.out_valid && !out_ready) begin
          held_v = 1'b1;
          held_s = if1.out_sample;
          chk("stall in_ready", int'(if1.in_ready), 0);
        end else begin
          held_v = 1'b0;
        end
        if (if1.out_valid && out_ready) begin
          chk("stream sample", int'(if1.out_sample), exp_v);
          exp_v++;
          got++;
        end
        if (in_valid && if1.in_ready) sent++;
        @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("stream delivered", got, 8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
